// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states, stage stall/flush bundle,
// and the default vector beat count.
package pipe_ctrl_pkg;

    localparam int VBEATS_DEFAULT = 8;

    typedef enum logic [1:0] {
        HC_RUN  = 2'd0,
        HC_VMEM = 2'd1,
        HC_HALT = 2'd2
    } hc_state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_CTRL_NONE   = stage_ctrl_t'(8'b0000_0000);
    // Whole pipe held, with a bubble into MEM/WB so nothing retires twice.
    localparam stage_ctrl_t STAGE_CTRL_FREEZE = stage_ctrl_t'(8'b1111_0001);
    localparam stage_ctrl_t STAGE_CTRL_LOADUSE = stage_ctrl_t'(8'b1110_0010);
    localparam stage_ctrl_t STAGE_CTRL_BRANCH = stage_ctrl_t'(8'b0000_1100);

    function automatic logic any_stall(input stage_ctrl_t c);
        return c.stall_if | c.stall_id | c.stall_ex | c.stall_mem;
    endfunction

endpackage

// File: rtl/vmem_beat_sequencer.sv
// Beat counter and mem_req/mem_ack handshake for multi-beat vector transfers;
// flags the acknowledge of the final beat to the hazard FSM.
module vmem_beat_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int VBEATS = VBEATS_DEFAULT,
    localparam int BEAT_W = $clog2(VBEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [BEAT_W-1:0] mem_beat,
    output logic              last_beat_ack
);

    logic [BEAT_W-1:0] beat_r;
    logic              is_last_s;

    // Last-beat detect and handshake outputs.
    always_comb begin
        is_last_s     = (beat_r == BEAT_W'(VBEATS - 1));
        mem_req       = active;
        mem_beat      = beat_r;
        last_beat_ack = active & mem_ack & is_last_s;
    end

    // Beat counter: advances on each accepted beat, parked at zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (!active) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (mem_ack) begin
            beat_r <= is_last_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, vector memory
// freeze and halt. Optional perf counters under HAZARD_PERF_COUNTERS_EN.
module hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int VBEATS = VBEATS_DEFAULT,
    parameter int CNT_W  = 32,
    localparam int BEAT_W = $clog2(VBEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_fwd,
    input  logic              branch_taken_ex,
    input  logic              vmem_start,
    input  logic              mem_ack,
    input  logic              halt_req,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              mem_req,
    output logic [BEAT_W-1:0] mem_beat,
    output logic              vmem_done,
    output logic              halted
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    if ((VBEATS < 2) || ((VBEATS & (VBEATS - 1)) != 0)) begin : g_vbeats_check
        $error("VBEATS must be a power of two and at least 2");
    end

    hc_state_t         state_r;
    hc_state_t         state_nxt_s;
    logic              halt_pending_r;
    logic              halt_pending_nxt_s;
    logic              vmem_done_r;
    stage_ctrl_t       ctrl_s;
    stage_ctrl_t       ctrl_out_s;
    logic              halted_s;
    logic              branch_flush_s;
    logic              vmem_active_s;
    logic              last_beat_ack_s;
    logic              seq_req_s;
    logic [BEAT_W-1:0] seq_beat_s;

    assign vmem_active_s = (state_r == HC_VMEM);

    vmem_beat_sequencer #(
        .VBEATS (VBEATS)
    ) u_vmem_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .active        (vmem_active_s),
        .mem_ack       (mem_ack),
        .mem_req       (seq_req_s),
        .mem_beat      (seq_beat_s),
        .last_beat_ack (last_beat_ack_s)
    );

    // Next-state and stage controls; RUN priority is vmem > load-use > branch > halt.
    always_comb begin
        state_nxt_s        = state_r;
        halt_pending_nxt_s = halt_pending_r;
        ctrl_s             = STAGE_CTRL_NONE;
        halted_s           = 1'b0;
        branch_flush_s     = 1'b0;
        case (state_r)
            HC_RUN: begin
                if (vmem_start) begin
                    ctrl_s      = STAGE_CTRL_FREEZE;
                    state_nxt_s = HC_VMEM;
                end else if (stall_fwd) begin
                    // EX is held, so a taken branch here re-presents next cycle.
                    ctrl_s = STAGE_CTRL_LOADUSE;
                end else if (branch_taken_ex) begin
                    ctrl_s         = STAGE_CTRL_BRANCH;
                    branch_flush_s = 1'b1;
                end else if (halt_req) begin
                    state_nxt_s = HC_HALT;
                end else begin
                    state_nxt_s = HC_RUN;
                end
            end
            HC_VMEM: begin
                ctrl_s = STAGE_CTRL_FREEZE;
                if (halt_req) begin
                    halt_pending_nxt_s = 1'b1;
                end else begin
                    halt_pending_nxt_s = halt_pending_r;
                end
                // A transfer always runs to completion; halt is deferred.
                if (last_beat_ack_s) begin
                    state_nxt_s = (halt_pending_r | halt_req) ? HC_HALT : HC_RUN;
                end else begin
                    state_nxt_s = HC_VMEM;
                end
            end
            HC_HALT: begin
                ctrl_s   = STAGE_CTRL_FREEZE;
                halted_s = 1'b1;
                if (!halt_req) begin
                    state_nxt_s        = HC_RUN;
                    halt_pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = HC_HALT;
                end
            end
            default: begin
                state_nxt_s        = HC_RUN;
                halt_pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Output gating: every output is quiet while reset is held.
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = STAGE_CTRL_NONE;
            mem_req    = 1'b0;
            mem_beat   = {BEAT_W{1'b0}};
            vmem_done  = 1'b0;
            halted     = 1'b0;
        end else begin
            ctrl_out_s = ctrl_s;
            mem_req    = seq_req_s;
            mem_beat   = seq_beat_s;
            vmem_done  = vmem_done_r;
            halted     = halted_s;
        end
    end

    assign stall_if  = ctrl_out_s.stall_if;
    assign stall_id  = ctrl_out_s.stall_id;
    assign stall_ex  = ctrl_out_s.stall_ex;
    assign stall_mem = ctrl_out_s.stall_mem;
    assign flush_id  = ctrl_out_s.flush_id;
    assign flush_ex  = ctrl_out_s.flush_ex;
    assign flush_mem = ctrl_out_s.flush_mem;
    assign flush_wb  = ctrl_out_s.flush_wb;

    // FSM state, deferred-halt flag and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= HC_RUN;
            halt_pending_r <= 1'b0;
            vmem_done_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            halt_pending_r <= halt_pending_nxt_s;
            vmem_done_r    <= last_beat_ack_s;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_events_r;

    // Saturating stall-cycle and branch-flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_events_r <= {CNT_W{1'b0}};
        end else begin
            if (any_stall(ctrl_out_s) && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (branch_flush_s && (flush_events_r != {CNT_W{1'b1}})) begin
                flush_events_r <= flush_events_r + CNT_W'(1);
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;
`else
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares.
module tb_hazard_controller;

    localparam int VBEATS = 8;
    localparam int CNT_W  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall_fwd = 1'b0, branch_taken_ex = 1'b0, vmem_start = 1'b0;
    logic       mem_ack = 1'b0, halt_req = 1'b0;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_mem, flush_wb;
    logic       mem_req, vmem_done, halted;
    logic [2:0] mem_beat;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

    hazard_controller #(.VBEATS(VBEATS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall_fwd(stall_fwd),
        .branch_taken_ex(branch_taken_ex), .vmem_start(vmem_start),
        .mem_ack(mem_ack), .halt_req(halt_req),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
        .flush_mem(flush_mem), .flush_wb(flush_wb), .mem_req(mem_req),
        .mem_beat(mem_beat), .vmem_done(vmem_done), .halted(halted)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    // Expected vector: {sif,sid,sex,smem,fid,fex,fmem,fwb, req, beat[2:0], done, halted}
    typedef logic [13:0] out_t;
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_FRZ  = 8'b1111_0001;
    localparam logic [7:0] C_LU   = 8'b1110_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;

    function automatic out_t mk(input logic [7:0] c, input logic req,
                                input logic [2:0] b, input logic done, input logic hlt);
        return {c, req, b, done, hlt};
    endfunction

    function automatic out_t vm(input int b);
        return mk(C_FRZ, 1'b1, 3'(b), 1'b0, 1'b0);
    endfunction

    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Inputs vector order: {rst_n, stall_fwd, branch_taken_ex, vmem_start, mem_ack, halt_req}
    task automatic step(input logic [5:0] in, input out_t e);
        @(posedge clk);
        #1;
        {rst_n, stall_fwd, branch_taken_ex, vmem_start, mem_ack, halt_req} = in;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per cycle that has a queued expectation.
    always @(negedge clk) begin
        out_t act;
        out_t e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                   flush_mem, flush_wb, mem_req, mem_beat, vmem_done, halted};
            checks = checks + 1;
            if (act !== e) begin
                errors = errors + 1;
                $display("FAIL outputs cyc %0d: got %b want %b", cyc, act, e);
            end
        end
    end

    localparam out_t IDLE = 14'b0;
    localparam out_t FRZ  = {C_FRZ, 6'b0};
    localparam out_t LU   = {C_LU, 6'b0};
    localparam out_t BR   = {C_BR, 6'b0};
    localparam out_t HLT  = {C_FRZ, 6'b000001};

    initial begin
        // Reset, with hazard inputs active to prove outputs are gated.
        step(6'b0_11000, IDLE);
        step(6'b0_11010, IDLE);
        step(6'b1_00000, IDLE);

        // Load-use with simultaneous branch, then branch re-presents.
        step(6'b1_11000, LU);
        step(6'b1_01000, BR);
        step(6'b1_00000, IDLE);
        // mem_ack outside VMEM ignored.
        step(6'b1_00010, IDLE);

        // Vector transfer, ack every cycle.
        step(6'b1_00100, FRZ);
        for (int b = 0; b < VBEATS; b++) step(6'b1_00010, vm(b));
        step(6'b1_00000, mk(C_NONE, 1'b0, 3'd0, 1'b1, 1'b0));
        step(6'b1_00000, IDLE);

        // Ack every other cycle; load-use/branch ignored while waiting.
        step(6'b1_00100, FRZ);
        for (int b = 0; b < VBEATS; b++) begin
            step(6'b1_11000, vm(b));
            step(6'b1_00010, vm(b));
        end
        step(6'b1_00000, mk(C_NONE, 1'b0, 3'd0, 1'b1, 1'b0));
        step(6'b1_00000, IDLE);

        // Halt pulse at beat 2 is deferred until the transfer completes.
        step(6'b1_00100, FRZ);
        for (int b = 0; b < VBEATS; b++)
            step((b == 2) ? 6'b1_00011 : 6'b1_00010, vm(b));
        step(6'b1_00001, mk(C_FRZ, 1'b0, 3'd0, 1'b1, 1'b1));
        step(6'b1_00000, HLT);
        step(6'b1_00000, IDLE);

        // Halt from RUN; load-use outranks halt.
        step(6'b1_00001, IDLE);
        step(6'b1_00001, HLT);
        step(6'b1_00000, HLT);
        step(6'b1_10001, LU);
        step(6'b1_01000, BR);
        step(6'b1_00000, IDLE);

        // Reset mid-transfer at beat 3.
        step(6'b1_00100, FRZ);
        step(6'b1_00010, vm(0));
        step(6'b1_00010, vm(1));
        step(6'b1_00010, vm(2));
        step(6'b1_00000, vm(3));
        step(6'b0_00010, IDLE);
        step(6'b0_11000, IDLE);
        step(6'b1_00000, IDLE);
        step(6'b1_00000, IDLE);

        // Three branch flushes plus one full transfer (counter scenario).
        for (int i = 0; i < 3; i++) begin
            step(6'b1_01000, BR);
            step(6'b1_00000, IDLE);
        end
        step(6'b1_00100, FRZ);
        for (int b = 0; b < VBEATS; b++) step(6'b1_00010, vm(b));
        step(6'b1_00000, mk(C_NONE, 1'b0, 3'd0, 1'b1, 1'b0));
        step(6'b1_00000, IDLE);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

`ifdef HAZARD_PERF_COUNTERS_EN
        #1;
        checks = checks + 1;
        if (flush_events !== 32'd3) begin
            errors = errors + 1;
            $display("FAIL flush_events: got %0d want 3", flush_events);
        end
        checks = checks + 1;
        if (stall_cycles !== 32'd9) begin
            errors = errors + 1;
            $display("FAIL stall_cycles: got %0d want 9", stall_cycles);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
